rainbow_stream_gen: RTL and testbench
=====================================

RAINBOW_STREAM_GEN -- requirements
Module: rainbow_stream_gen

Interface
REQ-001 SHALL have parameter NUM_PIXELS, default 48: pixels per frame (>=1).
REQ-002 SHALL have parameter HUE_STEP, default 5: hue increment between adjacent pixels, mod 256.
REQ-003 SHALL have parameter PHASE_STEP, default 1: phase increment per completed frame, mod 256.
REQ-004 SHALL have parameter GAP_CYCLES, default 5000: idle cycles after each frame (WS2812 latch time at 100 MHz).
REQ-005 SHALL have ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  start/continue frames
- mode  in  2  00 rainbow, 01 solid, 10 off (black), 11 treated as rainbow
- solid_hue  in  8  wheel position used in solid mode
- m_ready  in  1  downstream accepts pixel
- m_valid  out  1  pixel available
- m_pixel  out  24  GRB-packed: [7:0] G, [15:8] R, [23:16] B
- m_px_num  out  max(1,clog2(NUM_PIXELS))  index of current pixel
- m_last  out  1  high with pixel NUM_PIXELS-1
- frame_done  out  1  one-cycle pulse per completed frame
- phase  out  8  current frame phase

Function
REQ-006 SHALL implement FSM IDLE, STREAM, GAP; reset state IDLE.
REQ-007 IDLE: m_valid=0; when enable=1, SHALL latch mode, solid_hue, phase into frame registers and enter STREAM, asserting m_valid with pixel 0 on the next cycle.
REQ-008 Transfer occurs on a cycle with m_valid=1 and m_ready=1; m_pixel, m_px_num, m_last SHALL remain stable while m_valid=1 and m_ready=0.
REQ-009 On transfer of pixel i<NUM_PIXELS-1, the next cycle SHALL present pixel i+1 (no bubble under continuous m_ready).
REQ-010 Pixel i hue SHALL be (phase + i*HUE_STEP) mod 256, computed by an 8-bit accumulator that wraps; solid mode hue = latched solid_hue for all pixels; off mode pixel = 0x000000.
REQ-011 Wheel, pos p: p<85 -> R=255-3p, G=3p, B=0; 85<=p<170 -> q=p-85, G=255-3q, B=3q, R=0; p>=170 -> q=p-170, B=255-3q, R=3q, G=0.
REQ-012 On transfer of pixel NUM_PIXELS-1: frame_done SHALL pulse high the next cycle for exactly one cycle; phase SHALL become (phase+PHASE_STEP) mod 256 on the same edge; FSM enters GAP (or directly next state if GAP_CYCLES=0).
REQ-013 GAP: m_valid=0 for exactly GAP_CYCLES cycles; then STREAM (new latch per REQ-007) if enable=1, else IDLE.
REQ-014 Deasserting enable mid-frame SHALL NOT truncate the frame; it only prevents the next frame.
REQ-015 Changes to mode/solid_hue mid-frame SHALL take effect only at the next frame start.
REQ-016 Phase SHALL advance in all modes, including off.

Reset
REQ-017 rst_n=0 SHALL asynchronously force: state IDLE, m_valid=0, m_pixel=0, m_px_num=0, m_last=0, frame_done=0, phase=0, gap counter=0, regardless of in-progress frame.
REQ-018 After rst_n release, first frame SHALL start with phase 0 at pixel 0.

Configuration
REQ-019 Macro RAINBOW_BRIGHTNESS_EN defined: SHALL add input brightness[7:0], latched at frame start; each component c output as (c*(brightness+1))>>8, with no added latency.
REQ-020 Macro RAINBOW_BRIGHTNESS_EN undefined: port absent; components unscaled per REQ-011.

Verification
REQ-021 Reset, enable=1, m_ready=1, mode=00, defaults -> pixel 0 m_pixel=0x00FF00, pixel 1 m_pixel=0x00F00F, m_px_num 0,1 on consecutive cycles.
REQ-022 Continue to pixel 47 -> m_last=1 only on pixel 47; frame_done one-cycle pulse; phase=1; next frame pixel 0 = 0x00FC03.
REQ-023 m_ready=0 for 10 cycles while pixel 3 presented -> m_valid, m_pixel, m_px_num=3 unchanged all 10 cycles; pixel 4 follows transfer.
REQ-024 GAP_CYCLES=5000 -> m_valid low exactly 5000 cycles between pixel-47 transfer and next pixel 0; enable dropped during gap -> IDLE, no further pixels.
REQ-025 Phase forced to 250 via 250 frames -> pixel 2 hue 4 -> m_pixel=0x00F30C; mode=10 -> 48 pixels of 0x000000, phase still increments.
REQ-026 rst_n low mid-frame at pixel 20 -> m_valid=0, phase=0 immediately; after release next frame restarts at pixel 0 = 0x00FF00.

Source files
------------

// File: rtl/rainbow_stream_gen.sv
// Rainbow pixel stream generator for WS2812-style strings: colour-wheel frames, solid or off modes, latch gap.
// Optional build macro RAINBOW_BRIGHTNESS_EN adds a per-frame brightness scaler on every colour component.
module rainbow_stream_gen #(
    parameter int NUM_PIXELS = 48,
    parameter int HUE_STEP   = 5,
    parameter int PHASE_STEP = 1,
    parameter int GAP_CYCLES = 5000,
    localparam int PXW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1,
    localparam int GW  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           enable,
    input  logic [1:0]     mode,
    input  logic [7:0]     solid_hue,
`ifdef RAINBOW_BRIGHTNESS_EN
    input  logic [7:0]     brightness,
`endif
    input  logic           m_ready,
    output logic           m_valid,
    output logic [23:0]    m_pixel,
    output logic [PXW-1:0] m_px_num,
    output logic           m_last,
    output logic           frame_done,
    output logic [7:0]     phase
);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_GAP} state_t;

    state_t         state_q, state_d;
    logic [1:0]     mode_q, mode_d;
    logic [7:0]     solid_q, solid_d;
    logic [7:0]     hue_q, hue_d;
    logic [7:0]     phase_q, phase_d;
    logic [PXW-1:0] px_q, px_d;
    logic [GW-1:0]  gap_q, gap_d;
    logic           done_q, done_d;
    logic           start;
    logic [7:0]     start_phase;
    logic           last_px;
`ifdef RAINBOW_BRIGHTNESS_EN
    logic [7:0]     bright_q, bright_d;
`endif

    // A pixel transfers on any cycle with m_valid && m_ready; while m_valid is high and
    // m_ready is low, m_pixel/m_px_num/m_last hold because they depend only on registered state.
    assign last_px = (int'(px_q) == NUM_PIXELS - 1);

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        solid_d     = solid_q;
        hue_d       = hue_q;
        phase_d     = phase_q;
        px_d        = px_q;
        gap_d       = gap_q;
        done_d      = 1'b0;
        start       = 1'b0;
        start_phase = phase_q;
`ifdef RAINBOW_BRIGHTNESS_EN
        bright_d    = bright_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (enable) start = 1'b1;
            end
            S_STREAM: begin
                if (m_ready) begin
                    if (last_px) begin
                        phase_d = phase_q + 8'(PHASE_STEP);
                        done_d  = 1'b1;
                        px_d    = '0;
                        if (GAP_CYCLES == 0) begin
                            start_phase = phase_d;
                            if (enable) start = 1'b1;
                            else state_d = S_IDLE;
                        end else begin
                            state_d = S_GAP;
                            gap_d   = '0;
                        end
                    end else begin
                        px_d  = px_q + PXW'(1);
                        hue_d = hue_q + 8'(HUE_STEP);
                    end
                end
            end
            S_GAP: begin
                if (int'(gap_q) == GAP_CYCLES - 1) begin
                    gap_d = '0;
                    if (enable) start = 1'b1;
                    else state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Frame-start latch: mode, solid hue and phase are frozen for the whole frame.
        if (start) begin
            state_d = S_STREAM;
            mode_d  = mode;
            solid_d = solid_hue;
            hue_d   = start_phase;
            px_d    = '0;
`ifdef RAINBOW_BRIGHTNESS_EN
            bright_d = brightness;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mode_q   <= 2'b00;
            solid_q  <= 8'd0;
            hue_q    <= 8'd0;
            phase_q  <= 8'd0;
            px_q     <= '0;
            gap_q    <= '0;
            done_q   <= 1'b0;
`ifdef RAINBOW_BRIGHTNESS_EN
            bright_q <= 8'd0;
`endif
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            solid_q  <= solid_d;
            hue_q    <= hue_d;
            phase_q  <= phase_d;
            px_q     <= px_d;
            gap_q    <= gap_d;
            done_q   <= done_d;
`ifdef RAINBOW_BRIGHTNESS_EN
            bright_q <= bright_d;
`endif
        end
    end

    // Returns {B, R, G}, matching the GRB wire packing with G in the low byte.
    function automatic logic [23:0] wheel(input logic [7:0] p);
        logic [7:0] q;
        logic [7:0] t;
        if (p < 8'd85) begin
            t = 8'd3 * p;
            return {8'd0, 8'd255 - t, t};
        end else if (p < 8'd170) begin
            q = p - 8'd85;
            t = 8'd3 * q;
            return {t, 8'd0, 8'd255 - t};
        end else begin
            q = p - 8'd170;
            t = 8'd3 * q;
            return {8'd255 - t, t, 8'd0};
        end
    endfunction

`ifdef RAINBOW_BRIGHTNESS_EN
    function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] prod;
        prod = {8'd0, c} * ({8'd0, b} + 16'd1);
        return prod[15:8];
    endfunction
`endif

    logic [7:0]  px_hue;
    logic [23:0] px_raw;
    logic [23:0] px_col;

    assign px_hue = (mode_q == 2'b01) ? solid_q : hue_q;
    assign px_raw = wheel(px_hue);
`ifdef RAINBOW_BRIGHTNESS_EN
    assign px_col = {scale(px_raw[23:16], bright_q), scale(px_raw[15:8], bright_q),
                     scale(px_raw[7:0], bright_q)};
`else
    assign px_col = px_raw;
`endif

    assign m_valid    = (state_q == S_STREAM);
    assign m_pixel    = (m_valid && mode_q != 2'b10) ? px_col : 24'd0;
    assign m_px_num   = px_q;
    assign m_last     = m_valid && last_px;
    assign frame_done = done_q;
    assign phase      = phase_q;

endmodule

// File: tb/tb_rainbow_stream_gen.sv
// Directed bench for rainbow_stream_gen: a default-parameter instance for streaming, stall, gap,
// mode and reset behaviour, plus a short-gap instance used to reach phase 250 quickly.
module tb_rainbow_stream_gen;

    localparam int PXW = 6;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic           en, rdy;
    logic [1:0]     md;
    logic [7:0]     sh;
    logic           a_valid, a_last, a_done;
    logic [23:0]    a_pixel;
    logic [PXW-1:0] a_num;
    logic [7:0]     a_phase;

    logic           en_b;
    logic           rdy_b;
    logic [1:0]     md_b;
    logic [7:0]     sh_b;
    logic           b_valid, b_last, b_done;
    logic [23:0]    b_pixel;
    logic [PXW-1:0] b_num;
    logic [7:0]     b_phase;

    rainbow_stream_gen dut (
        .clk(clk), .rst_n(rst_n), .enable(en), .mode(md), .solid_hue(sh),
`ifdef RAINBOW_BRIGHTNESS_EN
        .brightness(8'd255),
`endif
        .m_ready(rdy), .m_valid(a_valid), .m_pixel(a_pixel), .m_px_num(a_num),
        .m_last(a_last), .frame_done(a_done), .phase(a_phase)
    );

    rainbow_stream_gen #(.NUM_PIXELS(48), .HUE_STEP(5), .PHASE_STEP(1), .GAP_CYCLES(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(en_b), .mode(md_b), .solid_hue(sh_b),
`ifdef RAINBOW_BRIGHTNESS_EN
        .brightness(8'd255),
`endif
        .m_ready(rdy_b), .m_valid(b_valid), .m_pixel(b_pixel), .m_px_num(b_num),
        .m_last(b_last), .frame_done(b_done), .phase(b_phase)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference colour: {B, R, G}, off mode black.
    function automatic logic [23:0] model_px(input logic [1:0] m, input int hue);
        int p, r, g, b;
        logic [23:0] res;
        p = hue % 256;
        if (p < 85) begin
            r = 255 - 3 * p; g = 3 * p; b = 0;
        end else if (p < 170) begin
            r = 0; g = 255 - 3 * (p - 85); b = 3 * (p - 85);
        end else begin
            r = 3 * (p - 170); g = 0; b = 255 - 3 * (p - 170);
        end
        res = {b[7:0], r[7:0], g[7:0]};
        if (m == 2'b10) res = 24'd0;
        return res;
    endfunction

    // Walks one frame of dut, sampling at negedges. Returns at the negedge after the last
    // transfer, or immediately after asserting reset at pixel rst_at.
    task automatic run_frame(input string tag, input logic [1:0] m, input int base, input int step,
                             input logic [23:0] exp0, input logic [23:0] exp1,
                             input int stall_at, input int drop_at, input int rst_at);
        int n;
        logic [23:0] held;
        for (int i = 0; i < 48; i++) begin
            if (i == 0) begin
                n = 0;
                while (!a_valid && n < 6000) begin
                    @(negedge clk);
                    n++;
                end
            end
            chk($sformatf("%s_valid%0d", tag, i), a_valid, 1);
            chk($sformatf("%s_num%0d", tag, i), a_num, i);
            chk($sformatf("%s_px%0d", tag, i), a_pixel, model_px(m, base + i * step));
            chk($sformatf("%s_last%0d", tag, i), a_last, (i == 47));
            if (i == 0) chk({tag, "_px0_const"}, a_pixel, exp0);
            if (i == 1) chk({tag, "_px1_const"}, a_pixel, exp1);
            if (i == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk({tag, "_rst_valid"}, a_valid, 0);
                chk({tag, "_rst_phase"}, a_phase, 0);
                chk({tag, "_rst_num"}, a_num, 0);
                chk({tag, "_rst_pixel"}, a_pixel, 0);
                chk({tag, "_rst_last"}, a_last, 0);
                return;
            end
            if (i == stall_at) begin
                held = a_pixel;
                rdy  = 1'b0;
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    chk($sformatf("%s_stall_valid%0d", tag, k), a_valid, 1);
                    chk($sformatf("%s_stall_px%0d", tag, k), a_pixel, held);
                    chk($sformatf("%s_stall_num%0d", tag, k), a_num, i);
                end
                rdy = 1'b1;
            end
            if (i == drop_at) begin
                en = 1'b0;
                md = 2'b10;
                sh = 8'd77;
            end
            @(negedge clk);
        end
        chk({tag, "_done_pulse"}, a_done, 1);
        chk({tag, "_valid_after"}, a_valid, 0);
    endtask

    // Watches dut for cycles negedges; counts valid and frame_done highs.
    task automatic quiet_window(input string tag, input int cycles);
        int seen_v, seen_d;
        seen_v = 0;
        seen_d = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (a_valid) seen_v++;
            if (a_done) seen_d++;
        end
        chk({tag, "_no_valid"}, seen_v, 0);
        chk({tag, "_no_done"}, seen_d, 0);
    endtask

    initial begin
        int n, gap;
        rst_n = 1'b0;
        en = 1'b0; rdy = 1'b1; md = 2'b00; sh = 8'd0;
        en_b = 1'b0; rdy_b = 1'b1; md_b = 2'b00; sh_b = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_valid", a_valid, 0);
        chk("rst_pixel", a_pixel, 0);
        chk("rst_num", a_num, 0);
        chk("rst_last", a_last, 0);
        chk("rst_done", a_done, 0);
        chk("rst_phase", a_phase, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_valid", a_valid, 0);

        // Short-gap instance: run up to the frame with phase 250, pixel 2 hue wraps to 4.
        en_b = 1'b1;
        n = 0;
        while (!(b_phase == 8'd250 && b_valid && b_num == 2) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("b_reach_phase250", (n < 20000), 1);
        chk("b_px2_phase250", b_pixel, 24'h00F30C);
        en_b = 1'b0;

        // Frame 0: rainbow, stall 10 cycles on pixel 3.
        en = 1'b1; rdy = 1'b1; md = 2'b00;
        run_frame("f0", 2'b00, 0, 5, 24'h00FF00, 24'h00F00F, 3, -1, -1);
        chk("f0_phase", a_phase, 1);
        gap = 1;
        @(negedge clk);
        chk("f0_done_one_cycle", a_done, 0);
        while (!a_valid && gap < 6000) begin
            gap++;
            @(negedge clk);
        end
        chk("f0_gap_len", gap, 5000);

        // Frame 1: enable and mode changed mid-frame; frame completes unchanged, then IDLE.
        run_frame("f1", 2'b00, 1, 5, 24'h00FC03, 24'h00ED12, -1, 10, -1);
        chk("f1_phase", a_phase, 2);
        quiet_window("f1_idle", 5100);
        chk("f1_idle_phase", a_phase, 2);

        // Frame 2: off mode still advances phase; enable dropped during gap.
        en = 1'b1;
        run_frame("f2", 2'b10, 2, 5, 24'h000000, 24'h000000, -1, -1, -1);
        chk("f2_phase", a_phase, 3);
        en = 1'b0;
        quiet_window("f2_idle", 5100);

        // Frame 3: solid hue 100, reset asserted at pixel 20.
        md = 2'b01; sh = 8'd100; en = 1'b1;
        run_frame("f3", 2'b01, 100, 0, 24'h2D00D2, 24'h2D00D2, -1, -1, 20);
        @(negedge clk);
        rst_n = 1'b1;
        md = 2'b00;
        run_frame("f4", 2'b00, 0, 5, 24'h00FF00, 24'h00F00F, -1, -1, -1);
        chk("f4_phase", a_phase, 1);
        en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
